mem_stage: RTL and testbench

- Memory-access stage of the 5-stage pipeline. It sits between the EX/MEM register and WB, and absorbs the MEM/WB register: its outputs feed wb_stage directly.
- Executes RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) over a req/gnt/rvalid data-memory bus.
- Stalls the upstream pipeline while a bus transaction is outstanding.
- All other instructions pass through with one cycle of latency.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/mem_align_unit.sv | 72 +++++++
 rtl/mem_stage.sv | 159 +++++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcodes, funct3 codes and the memory-stage state type.
package cpu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // True when funct3 names a real access width for the given direction.
    function automatic logic mem_f3_ok(input logic load, input logic [2:0] f3);
        if (load)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane logic for the memory stage: store byte enables and lane
// replication, load byte/half extraction with sign/zero extension, and the
// misalignment flag. Optional check enabled by MEM_MISALIGN_CHECK_EN; when it
// is undefined the flag is tied low and low address bits only pick lanes.
module mem_align_unit
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: byte enables from width and address, data replicated across lanes.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3)
            F3_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend according to funct3.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = rdata;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    // Halfwords need a[0]=0, words need a[1:0]=0; bytes are always aligned.
    always_comb begin
        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage pipeline, absorbing the MEM/WB register.
// Runs RV32I loads/stores over a req/gnt/rvalid bus, stalls upstream while an
// access is outstanding, and aborts with an err pulse after TIMEOUT cycles.
// Optional misalignment trap enabled by MEM_MISALIGN_CHECK_EN.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_store_data,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_result,
    output logic        err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      hold_reg;
    logic             out_valid_reg;
    logic [31:0]      out_instr_reg;
    logic [31:0]      out_result_reg;
    logic             err_reg;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        f3_ok;
    logic        timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        misaligned;

    assign is_load     = (in_instr[6:0] == OPC_LOAD);
    assign is_store    = (in_instr[6:0] == OPC_STORE);
    assign is_mem      = in_valid & (is_load | is_store);
    assign f3_ok       = mem_f3_ok(is_load, in_instr[14:12]);
    assign timeout_hit = (cnt_reg == CNT_LAST);

    mem_align_unit u_align (
        .funct3     (in_instr[14:12]),
        .addr_lo    (in_alu[1:0]),
        .store_data (in_store_data),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // Bus fields come straight from the frozen EX/MEM register; req is a pure state decode.
    assign dmem_req   = (state_reg == REQ);
    assign dmem_we    = is_store;
    assign dmem_addr  = {in_alu[31:2], 2'b00};
    assign dmem_be    = lane_be;
    assign dmem_wdata = lane_wdata;

    assign out_valid  = out_valid_reg;
    assign out_instr  = out_instr_reg;
    assign out_result = out_result_reg;
    assign err        = err_reg;

    // Upstream freeze: only a legal access in flight holds the pipe; a timeout cycle releases it.
    always_comb begin
        stall = 1'b0;
        case (state_reg)
            IDLE:      stall = is_mem & f3_ok & ~misaligned;
            REQ, WAIT: stall = ~timeout_hit;
            default:   stall = 1'b0;
        endcase
    end

    // Access sequencer with the MEM/WB outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            hold_reg       <= '0;
            out_valid_reg  <= 1'b0;
            out_instr_reg  <= '0;
            out_result_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!is_mem) begin
                        out_valid_reg  <= in_valid;
                        out_instr_reg  <= in_valid ? in_instr : 32'h0;
                        out_result_reg <= in_alu;
                    end else if (!f3_ok || misaligned) begin
                        // Illegal access: drop it as a bubble and flag it.
                        out_valid_reg  <= 1'b0;
                        out_instr_reg  <= '0;
                        out_result_reg <= in_alu;
                        err_reg        <= 1'b1;
                    end else begin
                        out_valid_reg <= 1'b0;
                        out_instr_reg <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= REQ;
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        err_reg       <= 1'b1;
                        out_valid_reg <= 1'b0;
                        out_instr_reg <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (dmem_gnt)
                            state_reg <= is_store ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (timeout_hit) begin
                        err_reg       <= 1'b1;
                        out_valid_reg <= 1'b0;
                        out_instr_reg <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (dmem_rvalid) begin
                            hold_reg  <= load_data;
                            state_reg <= DONE;
                        end
                    end
                end
                default: begin
                    // DONE: retire; EX/MEM advances on this same edge.
                    out_valid_reg  <= 1'b1;
                    out_instr_reg  <= in_instr;
                    out_result_reg <= is_load ? hold_reg : in_alu;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage. Honours MEM_MISALIGN_CHECK_EN
// for the misaligned-word vector.
module tb_mem_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_alu;
    logic [31:0] in_store_data;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_result;
    logic        err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] ADDI = 32'h00500093;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_alu        (in_alu),
        .in_store_data (in_store_data),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_result    (out_result),
        .err           (err),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld(input logic [2:0] f3);
        return {12'h000, 5'd2, f3, 5'd3, OPC_LOAD};
    endfunction

    function automatic logic [31:0] st(input logic [2:0] f3);
        return {7'h00, 5'd4, 5'd2, f3, 5'd0, OPC_STORE};
    endfunction

    // Drive a bubble for one cycle.
    task automatic bubble();
        in_valid = 1'b0; in_instr = '0; in_alu = '0; in_store_data = '0;
        @(posedge clk); #1;
    endtask

    // Present one instruction and act as the memory until the stage releases the stall.
    // Returns at posedge+1 of the edge on which the instruction leaves EX/MEM.
    task automatic run_op(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                          output int stalls, output int reqs, output logic we,
                          output logic [3:0] be, output logic [31:0] addr,
                          output logic [31:0] wdata, output logic stable);
        int waits;
        bit load_granted;
        bit done;
        stalls = 0; reqs = 0; waits = 0; load_granted = 0; done = 0; stable = 1'b1;
        we = 1'b0; be = '0; addr = '0; wdata = '0;
        in_valid = 1'b1; in_instr = instr; in_alu = alu; in_store_data = sdata; dmem_rdata = rdata;
        for (int i = 0; i < 64 && !done; i++) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            #1;
            if (dmem_req) begin
                if (reqs > 0 && (dmem_be !== be || dmem_wdata !== wdata ||
                                 dmem_addr !== addr || dmem_we !== we))
                    stable = 1'b0;
                reqs++;
                we = dmem_we; be = dmem_be; addr = dmem_addr; wdata = dmem_wdata;
                if (reqs > gnt_dly) begin
                    dmem_gnt = 1'b1;
                    if (instr[6:0] == OPC_LOAD) load_granted = 1;
                end
            end else if (load_granted) begin
                waits++;
                if (waits > rv_dly) dmem_rvalid = 1'b1;
            end
            if (stall) stalls++;
            else done = 1;
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("op_terminated", {31'b0, done}, 32'd1);
        $display("op instr=0x%08h addr=0x%08h stalls=%0d reqs=%0d out_valid=%0b result=0x%08h err=%0b",
                 instr, alu, stalls, reqs, out_valid, out_result, err);
    endtask

    // Run a load with zero-wait memory and check retirement and result.
    task automatic load_vec(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input int rv_dly,
                            input int exp_stalls, input logic [31:0] exp_res);
        int s, r; logic we_o, stab; logic [3:0] be_o; logic [31:0] ad, wd;
        run_op(ld(f3), a, 32'h0, rdata, 0, rv_dly, s, r, we_o, be_o, ad, wd, stab);
        chk({tag, "_stalls"}, s, exp_stalls);
        chk({tag, "_we"}, {31'b0, we_o}, 32'd0);
        chk({tag, "_addr"}, ad, {a[31:2], 2'b00});
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, ld(f3));
        chk({tag, "_result"}, out_result, exp_res);
        bubble();
    endtask

    initial begin
        int s, r; logic we_o, stab; logic [3:0] be_o; logic [31:0] ad, wd;

        rst = 1'b1; in_valid = 0; in_instr = 0; in_alu = 0; in_store_data = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;

        // ADDI passes through with one cycle latency and no stall.
        run_op(ADDI, 32'd5, 32'h0, 32'h0, 0, 0, s, r, we_o, be_o, ad, wd, stab);
        chk("addi_stalls", s, 0);
        chk("addi_reqs", r, 0);
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_instr", out_instr, ADDI);
        chk("addi_result", out_result, 32'd5);
        bubble();
        chk("bubble_valid", {31'b0, out_valid}, 32'd0);
        chk("bubble_instr", out_instr, 32'd0);

        // SW, zero-wait grant.
        run_op(st(F3_W), 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, s, r, we_o, be_o, ad, wd, stab);
        chk("sw_stalls", s, 2);
        chk("sw_reqs", r, 1);
        chk("sw_we", {31'b0, we_o}, 32'd1);
        chk("sw_addr", ad, 32'h10);
        chk("sw_be", {28'b0, be_o}, 32'hF);
        chk("sw_wdata", wd, 32'hDEADBEEF);
        chk("sw_valid", {31'b0, out_valid}, 32'd1);
        chk("sw_instr", out_instr, st(F3_W));
        chk("sw_result", out_result, 32'h10);
        bubble();

        // Load lane extraction / extension.
        load_vec("lb13",  F3_B,  32'h13, 32'h80FF1234, 0, 3, 32'hFFFFFF80);
        load_vec("lbu13", F3_BU, 32'h13, 32'h80FF1234, 0, 3, 32'h00000080);
        load_vec("lhu12", F3_HU, 32'h12, 32'h80FF1234, 0, 3, 32'h000080FF);
        load_vec("lh12",  F3_H,  32'h12, 32'h80FF1234, 0, 3, 32'hFFFF80FF);
        load_vec("lh10",  F3_H,  32'h10, 32'h80FF1234, 0, 3, 32'h00001234);
        load_vec("lb11",  F3_B,  32'h11, 32'h80FF1234, 0, 3, 32'h00000012);
        load_vec("lw_rv2", F3_W, 32'h24, 32'hCAFEF00D, 2, 5, 32'hCAFEF00D);

        // SH with delayed grant: lanes held stable, five stall cycles.
        run_op(st(F3_H), 32'h12, 32'h0000ABCD, 32'h0, 3, 0, s, r, we_o, be_o, ad, wd, stab);
        chk("sh_stalls", s, 5);
        chk("sh_reqs", r, 4);
        chk("sh_be", {28'b0, be_o}, 32'hC);
        chk("sh_wdata", wd, 32'hABCDABCD);
        chk("sh_stable", {31'b0, stab}, 32'd1);
        chk("sh_valid", {31'b0, out_valid}, 32'd1);
        bubble();

        // SB lane select.
        run_op(st(F3_B), 32'h11, 32'h0000005A, 32'h0, 0, 0, s, r, we_o, be_o, ad, wd, stab);
        chk("sb_be", {28'b0, be_o}, 32'h2);
        chk("sb_wdata", wd, 32'h5A5A5A5A);
        chk("sb_stalls", s, 2);
        bubble();

        // LW with no grant: timeout after 16 request cycles.
        run_op(ld(F3_W), 32'h40, 32'h0, 32'h0, 1000, 0, s, r, we_o, be_o, ad, wd, stab);
        chk("to_stalls", s, 16);
        chk("to_reqs", r, 16);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_valid", {31'b0, out_valid}, 32'd0);
        chk("to_instr", out_instr, 32'd0);
        bubble();
        chk("to_err_pulse", {31'b0, err}, 32'd0);
        run_op(ADDI, 32'd7, 32'h0, 32'h0, 0, 0, s, r, we_o, be_o, ad, wd, stab);
        chk("to_addi_valid", {31'b0, out_valid}, 32'd1);
        chk("to_addi_result", out_result, 32'd7);
        bubble();

        // Unsupported load funct3: bubble plus err, no stall.
        run_op({12'h0, 5'd2, 3'b011, 5'd3, OPC_LOAD}, 32'h20, 32'h0, 32'h0, 0, 0,
               s, r, we_o, be_o, ad, wd, stab);
        chk("badf3_stalls", s, 0);
        chk("badf3_reqs", r, 0);
        chk("badf3_err", {31'b0, err}, 32'd1);
        chk("badf3_valid", {31'b0, out_valid}, 32'd0);
        bubble();

        // Misaligned LW.
        run_op(ld(F3_W), 32'h11, 32'h0, 32'h11223344, 0, 0, s, r, we_o, be_o, ad, wd, stab);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_stalls", s, 0);
        chk("mis_reqs", r, 0);
        chk("mis_err", {31'b0, err}, 32'd1);
        chk("mis_valid", {31'b0, out_valid}, 32'd0);
        chk("mis_instr", out_instr, 32'd0);
`else
        chk("mis_stalls", s, 3);
        chk("mis_reqs", r, 1);
        chk("mis_addr", ad, 32'h10);
        chk("mis_be", {28'b0, be_o}, 32'hF);
        chk("mis_err", {31'b0, err}, 32'd0);
        chk("mis_result", out_result, 32'h11223344);
`endif
        bubble();
        chk("mis_err_pulse", {31'b0, err}, 32'd0);

        // Reset in WAIT aborts the access; a late rvalid is ignored.
        run_op(ADDI, 32'd9, 32'h0, 32'h0, 0, 0, s, r, we_o, be_o, ad, wd, stab);
        in_valid = 1'b1; in_instr = ld(F3_W); in_alu = 32'h30; dmem_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        chk("rw_req", {31'b0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("rw_wait_stall", {31'b0, stall}, 32'd1);
        chk("rw_wait_req", {31'b0, dmem_req}, 32'd0);
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_alu = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rw_req_after", {31'b0, dmem_req}, 32'd0);
        chk("rw_valid_after", {31'b0, out_valid}, 32'd0);
        chk("rw_instr_after", out_instr, 32'd0);
        chk("rw_result_after", out_result, 32'd0);
        chk("rw_err_after", {31'b0, err}, 32'd0);
        dmem_rvalid = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("rw_late_valid", {31'b0, out_valid}, 32'd0);
        chk("rw_late_stall", {31'b0, stall}, 32'd0);
        chk("rw_late_req", {31'b0, dmem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
